// File: rtl/datapath_ctrl.sv
// Instruction sequencer for the register-file/ALU datapath: captures one 16-bit
// instruction per start request and walks the Moore state sequence that executes it.
module datapath_ctrl #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s,
  input  logic [15:0]  instr,
  output logic         w,
  output logic         err,
  output logic [2:0]   readnum,
  output logic [2:0]   writenum,
  output logic         write,
  output logic         loada,
  output logic         loadb,
  output logic         loadc,
  output logic         loads,
  output logic         asel,
  output logic         bsel,
  output logic [1:0]   vsel,
  output logic [1:0]   shift,
  output logic [1:0]   ALUop,
  output logic [W-1:0] sximm8
);

  // state | meaning
  // WAIT  | idle, w=1, accepts s
  // DEC   | decode IR, flag undefined
  // GETA  | read Rn into A
  // GETB  | read Rm into B
  // ALU   | shift/ALU, load C or status
  // WREG  | write C to Rd
  // WIMM  | write sximm8 to Rn
  typedef enum logic [2:0] {
    ST_WAIT, ST_DEC, ST_GETA, ST_GETB, ST_ALU, ST_WREG, ST_WIMM
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic [2:0] opc;
  logic [1:0] op;
  logic       is_movimm, is_movreg, is_alu, is_cmp, is_mvn;

  assign opc       = ir_q[15:13];
  assign op        = ir_q[12:11];
  assign is_movimm = (opc == 3'b110) && (op == 2'b10);
  assign is_movreg = (opc == 3'b110) && (op == 2'b00);
  assign is_alu    = (opc == 3'b101);
  assign is_cmp    = is_alu && (op == 2'b01);
  assign is_mvn    = is_alu && (op == 2'b11);

  assign sximm8 = {{(W-8){ir_q[7]}}, ir_q[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      ST_WAIT: if (s) begin
        ir_d    = instr;
        state_d = ST_DEC;
      end
      ST_DEC: begin
        if (is_movimm)                state_d = ST_WIMM;
        else if (is_movreg || is_mvn) state_d = ST_GETB;
        else if (is_alu)              state_d = ST_GETA;
        else                          state_d = ST_WAIT;
      end
      ST_GETA: state_d = ST_GETB;
      ST_GETB: state_d = ST_ALU;
      ST_ALU:  state_d = is_cmp ? ST_WAIT : ST_WREG;
      ST_WREG: state_d = ST_WAIT;
      ST_WIMM: state_d = ST_WAIT;
      default: state_d = ST_WAIT;
    endcase
  end

  always_comb begin
    w        = 1'b0;
    err      = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = 2'b00;
    shift    = 2'b00;
    ALUop    = 2'b00;
    case (state_q)
      ST_WAIT: w = 1'b1;
      ST_DEC:  err = !(is_movimm || is_movreg || is_alu);
      ST_GETA: begin
        readnum = ir_q[10:8];
        loada   = 1'b1;
      end
      ST_GETB: begin
        readnum = ir_q[2:0];
        loadb   = 1'b1;
      end
      ST_ALU: begin
        shift = ir_q[4:3];
        ALUop = is_movreg ? 2'b00 : op;
        // A operand is meaningless for single-source ops, so force it to zero
        asel  = is_movreg || is_mvn;
        loads = is_cmp;
        loadc = !is_cmp;
      end
      ST_WREG: begin
        writenum = ir_q[7:5];
        write    = 1'b1;
      end
      ST_WIMM: begin
        writenum = ir_q[10:8];
        vsel     = 2'b10;
        write    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
